// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package branch_predictor_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_SNT = 2'b00;
  localparam bp_ctr_t BP_WNT = 2'b01;
  localparam bp_ctr_t BP_WT  = 2'b10;
  localparam bp_ctr_t BP_ST  = 2'b11;

  typedef enum logic {
    BP_INIT,
    BP_RUN
  } bp_state_t;

endpackage

// File: rtl/branch_predictor_bp_sat_counter.sv
// Next-value logic for a 2-bit saturating direction counter.
module bp_sat_counter
  import branch_predictor_pkg::*;
(
  input  bp_ctr_t ctr,
  input  logic    taken,
  output bp_ctr_t ctr_next
);

  // Count up on taken, down on not-taken, sticking at the strong ends.
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != BP_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT+BTB: registered lookup for fetch, write-back port for execute.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ready,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic        pred_hit,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  bp_state_t        state, state_next;
  logic [IDX_W-1:0] cnt, cnt_next;

  logic             valid_q  [ENTRIES];
  bp_ctr_t          ctr_q    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];

  logic [IDX_W-1:0] upd_idx, f_idx;
  logic [TAG_W-1:0] upd_tag, f_tag;
  logic             upd_hit, upd_we;
  bp_ctr_t          sat_next, wr_ctr;
  logic [31:0]      wr_target;

  logic             bypass, e_valid;
  logic [TAG_W-1:0] e_tag;
  bp_ctr_t          e_ctr;
  logic [31:0]      e_target;
  logic             l_hit, l_taken;
  logic [31:0]      l_target;

  // The two low PC bits carry no information for word-aligned branches.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign ready = (state == BP_RUN);

  // State register for the table-clearing sweep and the run phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BP_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Sweep one entry per cycle, then switch to normal operation.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      BP_INIT: begin
        cnt_next = cnt + IDX_W'(1);
        if (cnt == IDX_W'(ENTRIES - 1)) state_next = BP_RUN;
      end
      BP_RUN:  cnt_next = '0;
      default: state_next = BP_INIT;
    endcase
  end

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[31:IDX_W+2];
  assign f_idx   = fetch_pc[IDX_W+1:2];
  assign f_tag   = fetch_pc[31:IDX_W+2];

  bp_sat_counter u_sat (
    .ctr      (ctr_q[upd_idx]),
    .taken    (upd_taken),
    .ctr_next (sat_next)
  );

  // Work out what the resolved branch writes: train on hit, allocate on taken miss.
  always_comb begin
    upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_we    = ready && upd_valid && (upd_hit || upd_taken);
    wr_ctr    = upd_hit ? sat_next : BP_WT;
    wr_target = upd_taken ? upd_target : target_q[upd_idx];
  end

  // Table storage: cleared entry by entry during the sweep, written by execute afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == BP_INIT) begin
        valid_q[cnt] <= 1'b0;
        ctr_q[cnt]   <= BP_WNT;
      end else if (upd_we) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        ctr_q[upd_idx]    <= wr_ctr;
        target_q[upd_idx] <= wr_target;
      end
    end
  end

  // Lookup sees the entry as it will be after this cycle's update (write-first).
  always_comb begin
    bypass   = upd_we && (upd_idx == f_idx);
    e_valid  = bypass ? 1'b1      : valid_q[f_idx];
    e_tag    = bypass ? upd_tag   : tag_q[f_idx];
    e_ctr    = bypass ? wr_ctr    : ctr_q[f_idx];
    e_target = bypass ? wr_target : target_q[f_idx];
    l_hit    = e_valid && (e_tag == f_tag);
    l_taken  = l_hit && e_ctr[1];
    l_target = l_taken ? e_target : fetch_pc + 32'd4;
  end

  // Prediction register; holds its last answer when fetch is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else if (ready && fetch_valid) begin
      pred_valid  <= 1'b1;
      pred_hit    <= l_hit;
      pred_taken  <= l_taken;
      pred_target <= l_target;
    end else begin
      pred_valid  <= 1'b0;
    end
  end

endmodule
